fishing_round_controller: RTL and testbench
===========================================

// Module: fishing_round_controller
// PURPOSE
// Sequences one fishing round around the difficulty selector: latches difficulty, runs the
// bite-wait and catch timers from fishTime/reelTime, and moves the hooked-fish LED position.
// Judges the position against the lose bounds and win zone, and keeps the BCD score that
// feeds back into the selector.
// Sits between the button/tick front end and the LED bar / seven-segment display logic.
// PARAMETERS
// START_POS  8   bit index of ledBar loaded on entry to REEL; lies inside every winZone
// PORTS
// CLK            in   1   system clock
// RST            in   1   synchronous reset, active-high
// msTick         in   1   1 kHz enable pulse, one CLK wide
// startBtn       in   1   one-cycle pulse, starts a round; ignored outside IDLE
// reelBtn        in   1   one-cycle pulse, moves fish one LED toward bit 0
// fishTime       in   20  BCD xx.xxx seconds from difficulty selector
// reelTime       in   12  BCD .xxx seconds from difficulty selector
// leftLoseBound  in   26  one-hot lose LED, high side
// rightLoseBound in   26  one-hot lose LED, low side
// winZone        in   26  mask; catch timer runs only while the fish is inside it
// holdDiff       out  1   1 = selector difficulty latch opaque
// useWaitTime    out  1   1 = selector drives the fixed wait time on fishTime
// ledBar         out  26  one-hot fish position; 0 when not in REEL
// score          out  8   BCD score {tens,ones}, 00..99
// roundWon       out  1   one-cycle pulse on a catch
// roundLost      out  1   one-cycle pulse on an escape
// state          out  3   current state code, for debug and display
// BEHAVIOUR
// - Reset (RST=1 at a CLK edge): state=IDLE. All outputs 0. Internal counters 0.
//   Reset applies mid-round and clears score.
// - States: IDLE=0, WAIT_LD=1, WAIT=2, REEL_LD=3, REEL=4, WIN=5, LOSE=6.
// - IDLE: holdDiff=0, useWaitTime=0. On startBtn: holdDiff<=1, useWaitTime<=1, go to WAIT_LD.
// - WAIT_LD: lasts one cycle so that fishTime settles to the wait time.
//   fishCnt<=fishTime, go to WAIT.
// - WAIT: on msTick, if fishCnt==0 then useWaitTime<=0 and go to REEL_LD; otherwise BCD-decrement fishCnt.
//   A load of N ms therefore takes N+1 ticks.
// - REEL_LD: lasts one cycle. fishCnt<=fishTime, reelCnt<=reelTime, pos<=1<<START_POS, go to REEL.
// - REEL, on each msTick:
//   - reelCnt==0 raises a drift and reloads reelCnt<=reelTime; otherwise BCD-decrement reelCnt.
//   - Drift only: pos<<=1. reelBtn only: pos>>=1. Both in the same cycle: pos unchanged.
//   - reelBtn is acted on at every CLK edge, not just on msTick edges.
//   - If (pos & winZone)!=0, BCD-decrement fishCnt; otherwise hold fishCnt (pause, no reload).
// - REEL judging uses the registered pos, once per cycle. Lose has priority over win.
//   - (pos & (leftLoseBound|rightLoseBound))!=0: go to LOSE.
//   - Otherwise, msTick with fishCnt==0 and pos inside winZone: go to WIN.
// - WIN: roundWon=1 for one cycle. score<=BCD score+1, saturating at 99.
//   Ones digit 9 wraps to 0 and carries into tens. Then go to IDLE.
// - LOSE: roundLost=1 for one cycle, score unchanged, go to IDLE.
// - ledBar=pos in REEL, 0 in every other state.
// - holdDiff is 1 in every state except IDLE.
// - All BCD decrements stop at 0 and never underflow. Every digit stays within 0..9.
// - All outputs are registered.
// TESTING
// - Reset: pulse RST in any state -> next cycle state=0, ledBar=0, score=8'h00,
//   holdDiff=0, useWaitTime=0.
// - Wait phase: fishTime=20'h04000 while useWaitTime=1, then startBtn -> holdDiff=1,
//   WAIT for exactly 4001 msTicks, then REEL with ledBar=26'h100 and useWaitTime=0.
// - Escape: reelTime=12'h990, leftLoseBound=1<<16, no reelBtn -> 8 drifts (one per 991 ticks)
//   reach bit 16 -> roundLost pulse, score unchanged, back to IDLE.
// - Catch and score: fishTime=20'h03000, pos held in winZone -> roundWon after 3001 ticks.
//   Score 8'h09 becomes 8'h10; score 8'h99 stays 8'h99.
// - Pause and collision: pos outside winZone leaves fishCnt frozen. reelBtn on the drift tick
//   leaves ledBar unchanged. startBtn during REEL is ignored.
// - Mid-round reset: RST during REEL with score=8'h05 -> IDLE, ledBar=0, score=8'h00,
//   no win/lose pulse.

Source files
------------

// File: rtl/fishing_round_controller.sv
// rtl/fishing_round_controller.sv - fishing round sequencer: wait/catch timers, fish position, win/lose judging, BCD score
module fishing_round_controller #(
  parameter int START_POS = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        msTick,
  input  logic        startBtn,
  input  logic        reelBtn,
  input  logic [19:0] fishTime,
  input  logic [11:0] reelTime,
  input  logic [25:0] leftLoseBound,
  input  logic [25:0] rightLoseBound,
  input  logic [25:0] winZone,
  output logic        holdDiff,
  output logic        useWaitTime,
  output logic [25:0] ledBar,
  output logic [7:0]  score,
  output logic        roundWon,
  output logic        roundLost,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_LD = 3'd1,
    S_WAIT    = 3'd2,
    S_REEL_LD = 3'd3,
    S_REEL    = 3'd4,
    S_WIN     = 3'd5,
    S_LOSE    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] fish_cnt_q, fish_cnt_d;
  logic [11:0] reel_cnt_q, reel_cnt_d;
  logic [25:0] pos_q, pos_d;
  logic [7:0]  score_q, score_d;
  logic        use_wait_q, use_wait_d;
  logic        hold_q, hold_d;
  logic [25:0] led_q, led_d;
  logic        won_q, won_d;
  logic        lost_q, lost_d;

  logic [19:0] reel_dec;
  logic [7:0]  score_inc;
  logic        in_win, at_lose, drift;

  // Decrement by one count in BCD; zero stays at zero.
  function automatic logic [19:0] bcd_dec(input logic [19:0] v);
    logic [19:0] r;
    logic        borrow;
    r      = v;
    borrow = (v != 20'h0);
    for (int i = 0; i < 5; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    fish_cnt_d = fish_cnt_q;
    reel_cnt_d = reel_cnt_q;
    pos_d      = pos_q;
    score_d    = score_q;
    use_wait_d = use_wait_q;

    reel_dec = bcd_dec({8'h00, reel_cnt_q});
    in_win   = |(pos_q & winZone);
    at_lose  = |(pos_q & (leftLoseBound | rightLoseBound));
    drift    = msTick && (reel_cnt_q == 12'h000);

    if (score_q == 8'h99) begin
      score_inc = score_q;
    end else if (score_q[3:0] == 4'd9) begin
      score_inc = {score_q[7:4] + 4'd1, 4'd0};
    end else begin
      score_inc = {score_q[7:4], score_q[3:0] + 4'd1};
    end

    case (state_q)
      S_IDLE: begin
        if (startBtn) begin
          use_wait_d = 1'b1;
          state_d    = S_WAIT_LD;
        end
      end
      S_WAIT_LD: begin
        fish_cnt_d = fishTime;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (msTick) begin
          if (fish_cnt_q == 20'h0) begin
            use_wait_d = 1'b0;
            state_d    = S_REEL_LD;
          end else begin
            fish_cnt_d = bcd_dec(fish_cnt_q);
          end
        end
      end
      S_REEL_LD: begin
        fish_cnt_d = fishTime;
        reel_cnt_d = reelTime;
        pos_d      = 26'd1 << START_POS;
        state_d    = S_REEL;
      end
      S_REEL: begin
        if (msTick) begin
          reel_cnt_d = drift ? reelTime : reel_dec[11:0];
          if (in_win) fish_cnt_d = bcd_dec(fish_cnt_q);
        end
        // A drift and a reel press in the same cycle cancel out.
        if (drift && !reelBtn) begin
          pos_d = pos_q << 1;
        end else if (reelBtn && !drift) begin
          pos_d = pos_q >> 1;
        end
        if (at_lose) begin
          state_d = S_LOSE;
        end else if (msTick && (fish_cnt_q == 20'h0) && in_win) begin
          state_d = S_WIN;
        end
      end
      S_WIN: begin
        score_d = score_inc;
        state_d = S_IDLE;
      end
      S_LOSE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with state.
    hold_d = (state_d != S_IDLE);
    led_d  = (state_d == S_REEL) ? pos_d : 26'd0;
    won_d  = (state_d == S_WIN);
    lost_d = (state_d == S_LOSE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      fish_cnt_q <= 20'h0;
      reel_cnt_q <= 12'h0;
      pos_q      <= 26'd0;
      score_q    <= 8'h00;
      use_wait_q <= 1'b0;
      hold_q     <= 1'b0;
      led_q      <= 26'd0;
      won_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fish_cnt_q <= fish_cnt_d;
      reel_cnt_q <= reel_cnt_d;
      pos_q      <= pos_d;
      score_q    <= score_d;
      use_wait_q <= use_wait_d;
      hold_q     <= hold_d;
      led_q      <= led_d;
      won_q      <= won_d;
      lost_q     <= lost_d;
    end
  end

  assign holdDiff    = hold_q;
  assign useWaitTime = use_wait_q;
  assign ledBar      = led_q;
  assign score       = score_q;
  assign roundWon    = won_q;
  assign roundLost   = lost_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fishing_round_controller.sv
// tb/tb_fishing_round_controller.sv - directed bench for fishing_round_controller
module tb_fishing_round_controller;

  logic        CLK;
  logic        RST;
  logic        msTick;
  logic        startBtn;
  logic        reelBtn;
  logic [19:0] fishTime;
  logic [11:0] reelTime;
  logic [25:0] leftLoseBound;
  logic [25:0] rightLoseBound;
  logic [25:0] winZone;
  logic        holdDiff;
  logic        useWaitTime;
  logic [25:0] ledBar;
  logic [7:0]  score;
  logic        roundWon;
  logic        roundLost;
  logic [2:0]  state;

  logic [19:0] wait_val;
  logic [19:0] catch_val;
  int          n_cmp;
  int          n_bad;
  int          n;

  // Stand-in for the difficulty selector's fishTime mux.
  assign fishTime = useWaitTime ? wait_val : catch_val;

  fishing_round_controller #(.START_POS(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .msTick(msTick),
    .startBtn(startBtn),
    .reelBtn(reelBtn),
    .fishTime(fishTime),
    .reelTime(reelTime),
    .leftLoseBound(leftLoseBound),
    .rightLoseBound(rightLoseBound),
    .winZone(winZone),
    .holdDiff(holdDiff),
    .useWaitTime(useWaitTime),
    .ledBar(ledBar),
    .score(score),
    .roundWon(roundWon),
    .roundLost(roundLost),
    .state(state)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic tk, input logic rb, input logic sb);
    msTick   = tk;
    reelBtn  = rb;
    startBtn = sb;
    @(posedge CLK);
    #1;
    msTick   = 1'b0;
    reelBtn  = 1'b0;
    startBtn = 1'b0;
  endtask

  task automatic start_round();
    step(0, 0, 1);
    check("start_state", state, 3'd1);
    check("start_hold", holdDiff, 1'b1);
    check("start_usewait", useWaitTime, 1'b1);
    step(0, 0, 0);
    check("wait_state", state, 3'd2);
  endtask

  task automatic wait_phase(output int cnt);
    cnt = 0;
    while (state == 3'd2 && cnt < 6000) begin
      step(1, 0, 0);
      step(0, 0, 0);
      cnt++;
    end
  endtask

  task automatic reel_phase(output int cnt);
    cnt = 0;
    while (state == 3'd4 && cnt < 20000) begin
      step(1, 0, 0);
      cnt++;
      if (state == 3'd4) step(0, 0, 0);
    end
  endtask

  task automatic fast_win();
    int k;
    start_round();
    wait_phase(k);
    reel_phase(k);
    check("fast_ticks", k, 1);
    check("fast_won", roundWon, 1'b1);
    step(0, 0, 0);
    check("fast_idle", state, 3'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    RST = 1'b1;
    msTick = 1'b0; startBtn = 1'b0; reelBtn = 1'b0;
    wait_val = 20'h0; catch_val = 20'h0; reelTime = 12'h0;
    leftLoseBound = 26'd0; rightLoseBound = 26'd0; winZone = 26'd0;
    step(0, 0, 0);
    step(0, 0, 0);
    RST = 1'b0;
    check("rst_state", state, 3'd0);
    check("rst_led", ledBar, 26'd0);
    check("rst_score", score, 8'h00);
    check("rst_hold", holdDiff, 1'b0);
    check("rst_usewait", useWaitTime, 1'b0);

    // Full wait and catch: 4001 wait ticks, 3001 catch ticks, drifts every 1000 ticks
    wait_val = 20'h04000; catch_val = 20'h03000; reelTime = 12'h999;
    winZone = 26'h1FFFFFE; leftLoseBound = 26'h2000000; rightLoseBound = 26'h0000001;
    start_round();
    wait_phase(n);
    check("wait_ticks", n, 4001);
    check("reel_state", state, 3'd4);
    check("reel_led", ledBar, 26'h100);
    check("reel_usewait", useWaitTime, 1'b0);
    check("reel_hold", holdDiff, 1'b1);
    reel_phase(n);
    check("catch_ticks", n, 3001);
    check("win_state", state, 3'd5);
    check("win_pulse", roundWon, 1'b1);
    check("win_led", ledBar, 26'd0);
    step(0, 0, 0);
    check("win_idle", state, 3'd0);
    check("score_1", score, 8'h01);
    check("win_pulse_end", roundWon, 1'b0);
    check("idle_hold", holdDiff, 1'b0);

    // Escape: 8 drifts of 991 ticks from bit 8 to bit 16
    wait_val = 20'h0; catch_val = 20'h99999; reelTime = 12'h990;
    leftLoseBound = 26'd1 << 16;
    start_round();
    wait_phase(n);
    check("wait0_ticks", n, 1);
    reel_phase(n);
    check("escape_ticks", n, 7928);
    check("lose_state", state, 3'd6);
    check("lose_pulse", roundLost, 1'b1);
    check("lose_won", roundWon, 1'b0);
    check("lose_score", score, 8'h01);
    step(0, 0, 0);
    check("lose_idle", state, 3'd0);
    check("lose_pulse_end", roundLost, 1'b0);

    // Pause outside winZone, reel press between ticks, collision, startBtn ignored
    catch_val = 20'h00003; reelTime = 12'h002; winZone = 26'h100;
    leftLoseBound = 26'd1 << 20; rightLoseBound = 26'h0000001;
    start_round();
    wait_phase(n);
    check("p_led0", ledBar, 26'h100);
    step(0, 1, 0);
    check("p_btn_off_tick", ledBar, 26'h080);
    step(1, 0, 0); step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    step(1, 0, 0);
    check("p_drift", ledBar, 26'h100);
    step(0, 0, 1);
    check("p_start_ignored", state, 3'd4);
    step(1, 0, 0);
    check("p_frozen", state, 3'd4);
    step(0, 0, 0);
    step(1, 0, 0); step(0, 0, 0);
    step(1, 1, 0);
    check("p_collision_led", ledBar, 26'h100);
    check("p_collision_state", state, 3'd4);
    step(0, 0, 0);
    step(1, 0, 0);
    check("p_win", state, 3'd5);
    step(0, 0, 0);
    check("score_2", score, 8'h02);

    // Quick rounds
    catch_val = 20'h0; reelTime = 12'h999; winZone = 26'h1FFFFFE;
    leftLoseBound = 26'd0; rightLoseBound = 26'd0;
    repeat (3) fast_win();
    check("score_5", score, 8'h05);

    // Mid-round reset
    catch_val = 20'h00500;
    start_round();
    wait_phase(n);
    check("mr_in_reel", state, 3'd4);
    RST = 1'b1;
    step(1, 0, 0);
    RST = 1'b0;
    check("mr_state", state, 3'd0);
    check("mr_led", ledBar, 26'd0);
    check("mr_score", score, 8'h00);
    check("mr_won", roundWon, 1'b0);
    check("mr_lost", roundLost, 1'b0);
    check("mr_hold", holdDiff, 1'b0);
    check("mr_usewait", useWaitTime, 1'b0);
    step(0, 0, 0);
    check("mr_won2", roundWon, 1'b0);
    check("mr_lost2", roundLost, 1'b0);

    // Score carry and saturation
    catch_val = 20'h0;
    repeat (9) fast_win();
    check("score_9", score, 8'h09);
    fast_win();
    check("score_10", score, 8'h10);
    repeat (89) fast_win();
    check("score_99", score, 8'h99);
    fast_win();
    check("score_sat", score, 8'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
